spi_byte_receiver: RTL
======================

SPI_BYTE_RECEIVER -- requirements
Module: spi_byte_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in each pin synchronizer (legal range 2..4).
REQ-002 SHALL have parameter STATUS_BYTE, default 8'hA5, first byte shifted out on spi_miso in every frame.
REQ-003 SHALL have port clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port spi_sclk  input  1  SPI clock from the Teensy master, asynchronous to clk, mode 0 (idle low).
REQ-006 SHALL have port spi_mosi  input  1  SPI data in, MSB first.
REQ-007 SHALL have port spi_cs_n  input  1  SPI chip select, active-low; a frame lasts from its falling edge to its rising edge.
REQ-008 SHALL have port spi_miso  output  1  SPI data out, MSB first.
REQ-009 SHALL have port stream_data  output  8  last complete received byte; feeds the command decoder.
REQ-010 SHALL have port stream_valid  output  1  one-clk pulse when stream_data holds a new byte.
REQ-011 SHALL have port frame_start  output  1  one-clk pulse on the synchronized falling edge of spi_cs_n.
REQ-012 SHALL have port frame_error  output  1  one-clk pulse when spi_cs_n rises with a partial byte.
REQ-013 SHALL have port frame_bytes  output  8  count of complete bytes in the current or last frame.

Function
REQ-014 SHALL pass spi_sclk, spi_mosi and spi_cs_n each through a SYNC_STAGES-flop synchronizer, reset to sclk=0, mosi=0, cs_n=1, then register one more stage for edge detection.
REQ-015 SHALL detect sclk_rise, sclk_fall, cs_fall and cs_rise only from the last synchronizer stage and its delayed copy.
REQ-016 SHALL use two states: IDLE (cs_n high) and ACTIVE (cs_n low). IDLE->ACTIVE on cs_fall; ACTIVE->IDLE on cs_rise.
REQ-017 SHALL ignore SCLK edges in IDLE: no shift, no count.
REQ-018 On cs_fall SHALL clear the 3-bit bit counter, the receive shift register and frame_bytes, load the transmit register with STATUS_BYTE, and pulse frame_start.
REQ-019 On sclk_rise in ACTIVE SHALL shift the synchronized mosi into the receive shift register LSB (MSB first) and increment the bit counter, wrapping 7->0.
REQ-020 On the sclk_rise with bit counter = 7 SHALL register the completed byte {shift[6:0], mosi} to stream_data and pulse stream_valid at the next clk edge.
REQ-021 Latency from that sclk pin rising edge to stream_valid high SHALL be SYNC_STAGES+1 clk edges.
REQ-022 On the same event SHALL load the transmit register with the completed byte; the byte received is echoed during the next byte.
REQ-023 On the same event SHALL increment frame_bytes, saturating at 8'hFF.
REQ-024 spi_miso SHALL equal transmit register bit 7 in ACTIVE and 0 in IDLE.
REQ-025 On sclk_fall in ACTIVE SHALL shift the transmit register left only when bit counter != 0; at bit counter = 0 it holds, so the next byte's MSB stays presented.
REQ-026 On cs_rise with bit counter != 0 SHALL discard the partial byte, pulse frame_error, and leave stream_data and frame_bytes unchanged.
REQ-027 On cs_rise with bit counter = 0 SHALL not pulse frame_error.
REQ-028 If cs_rise and sclk_rise are detected in the same cycle, SHALL process cs_rise only; the SCLK edge is dropped.
REQ-029 stream_data SHALL hold its value between pulses.
REQ-030 SHALL not pulse stream_valid more than once per received byte.
REQ-031 Correct operation SHALL be guaranteed for f_clk >= 8 x f_sclk, with each SCLK phase >= SYNC_STAGES+2 clk periods.

Reset
REQ-032 While reset_n is low, SHALL force: state IDLE, counters 0, shift registers 0, stream_data 8'h00, stream_valid 0, frame_start 0, frame_error 0, frame_bytes 0, spi_miso 0.
REQ-033 After reset_n rises with spi_cs_n already low, SHALL stay in IDLE until a fresh cs_fall is detected.
REQ-034 Reset asserted mid-frame SHALL discard all in-flight bits without any pulse.

Verification
REQ-035 Frame of bytes 01,12,34 (clk 50 MHz, SCLK 1 MHz) -> three stream_valid pulses with data 01,12,34; frame_bytes=3; MISO bytes A5,01,12; no frame_error.
REQ-036 cs_n low, 5 SCLK cycles, cs_n high -> frame_error pulse; no stream_valid; stream_data holds its prior value.
REQ-037 SCLK toggling 8 times with cs_n high -> no stream_valid, no frame_start, spi_miso=0.
REQ-038 Single pin rise on the 8th SCLK -> stream_valid high exactly SYNC_STAGES+1 = 3 clk edges later, width 1 cycle.
REQ-039 reset_n pulsed low after 4 bits of byte 8'hFF, then a new frame with byte 8'h0F -> single stream_valid with data 0F.
REQ-040 Frame of 300 bytes -> frame_bytes saturates at FF; all 300 stream_valid pulses occur.

Source files
------------

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 slave byte receiver: synchronizes the SPI pins into clk, assembles
// MSB-first bytes, streams them out and echoes each received byte on MISO.
module spi_byte_receiver #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic [7:0] stream_data,
    output logic       stream_valid,
    output logic       frame_start,
    output logic       frame_error,
    output logic [7:0] frame_bytes
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Pin synchronizers; prime_q marks when the chain holds real pin samples.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   sclk_d1_q;
    logic                   cs_d1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            prime_q     <= '0;
            sclk_d1_q   <= 1'b0;
            cs_d1_q     <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            prime_q     <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            sclk_d1_q   <= sclk_sync_q[SYNC_STAGES-1];
            cs_d1_q     <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d1_q;
    assign sclk_fall = ~sclk_s & sclk_d1_q;
    assign cs_fall   = ~cs_s & cs_d1_q;
    assign cs_rise   = cs_s & ~cs_d1_q;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   rx_q, rx_d;
    logic [BYTE_W-1:0]   tx_q, tx_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic [BYTE_W-1:0]   bytes_q, bytes_d;
    logic                valid_q, valid_d;
    logic                start_q, start_d;
    logic                error_q, error_d;
    logic                miso_q, miso_d;
    logic                armed_q, armed_d;
    logic [BYTE_W-1:0]   rx_byte;

    assign rx_byte = {rx_q[BYTE_W-2:0], mosi_s};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        data_d    = data_q;
        bytes_d   = bytes_q;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        error_d   = 1'b0;
        // A frame may only open once cs_n has been seen high since reset.
        armed_d   = armed_q | (prime_q[SYNC_STAGES-1] & cs_s);

        unique case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    bytes_d   = '0;
                    tx_d      = STATUS_BYTE;
                    start_d   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    // cs_rise wins over a coincident SCLK edge; partial bits are dropped.
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    error_d   = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        data_d  = rx_byte;
                        valid_d = 1'b1;
                        tx_d    = rx_byte;
                        if (bytes_q != 8'hFF) begin
                            bytes_d = bytes_q + BYTE_W'(1);
                        end
                    end
                end else if (sclk_fall && (bit_cnt_q != '0)) begin
                    tx_d = {tx_q[BYTE_W-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        miso_d = (state_d == ACTIVE) ? tx_d[BYTE_W-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            data_q    <= '0;
            bytes_q   <= '0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            error_q   <= 1'b0;
            miso_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            data_q    <= data_d;
            bytes_q   <= bytes_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            error_q   <= error_d;
            miso_q    <= miso_d;
            armed_q   <= armed_d;
        end
    end

    assign spi_miso     = miso_q;
    assign stream_data  = data_q;
    assign stream_valid = valid_q;
    assign frame_start  = start_q;
    assign frame_error  = error_q;
    assign frame_bytes  = bytes_q;

endmodule
